// File: rtl/decode_pkg.sv
// decode_pkg: definitions shared by the decode stage and its immediate generator.
//   - RV32/RV64 base opcodes used to classify instructions
//   - imm_type_e: immediate format selected by opcode (I/S/B/U/J)
//   - XLEN-independent instruction field positions
//   - helper functions: imm_type_of(), writes_rd()
package decode_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam int OPC_LSB   = 0;
   localparam int OPC_W     = 7;
   localparam int RD_LSB    = 7;
   localparam int RS1_LSB   = 15;
   localparam int RS2_LSB   = 20;
   localparam int REG_IDX_W = 5;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_type_e;

   // Anything not explicitly S/B/U/J (loads, OP-IMM, JALR, ...) uses I format.
   function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
      case (opcode)
         OPC_STORE:          return IMM_S;
         OPC_BRANCH:         return IMM_B;
         OPC_LUI, OPC_AUIPC: return IMM_U;
         OPC_JAL:            return IMM_J;
         default:            return IMM_I;
      endcase
   endfunction

   // Stores and branches are the only formats without a destination register.
   function automatic logic writes_rd(input logic [6:0] opcode);
      return !((opcode == OPC_STORE) || (opcode == OPC_BRANCH));
   endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: builds the immediate of a 32-bit instruction word and sign-extends
// it to XLEN. Format (I/S/B/U/J) is chosen from the opcode.
// Ports:
//   instr_i  in  32    instruction word
//   imm_o    out XLEN  sign-extended immediate (U-type has [11:0] = 0)
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type_of(instr_i[OPC_LSB +: OPC_W]))
         IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U: imm32 = {instr_i[31:12], 12'b0};
         IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // U-type is sign-extended too, so LUI 0x80000 on RV64 gives 0xFFFFFFFF_80000000.
   assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with inline register file and one output
// register stage towards execute.
// Optional feature: define DECODE_STAGE_WB_BYPASS_EN to forward same-cycle
// writeback data to rs1/rs2 reads; otherwise reads see the pre-write value.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready, in_instr     handshake and instruction from fetch
//   in_alu_src/in_shift_imm/in_is_load  control bits with in_instr
//   wb_en/wb_rd/wb_data/wb_pc4/wb_sel_pc4  register-file write port
//   flush                           drop incoming instruction, empty output stage
//   out_valid/out_ready             handshake to execute
//   out_op_a/out_op_b/out_store_data/out_rd/out_is_load/out_reg_write  decoded fields
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; while out_valid=1 and out_ready=0 (no flush) all out_* fields hold.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic                 in_alu_src,
   input  logic                 in_shift_imm,
   input  logic                 in_is_load,
   input  logic                 wb_en,
   input  logic [4:0]           wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   input  logic [XLEN-1:0]      wb_pc4,
   input  logic                 wb_sel_pc4,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_op_a,
   output logic [XLEN-1:0]      out_op_b,
   output logic [XLEN-1:0]      out_store_data,
   output logic [4:0]           out_rd,
   output logic                 out_is_load,
   output logic                 out_reg_write
);

   // Always 32 entries so 5-bit indices fit; with NREGS=16 the top half is
   // never written and never read.
   logic [XLEN-1:0] rf_q [32];

   logic [REG_IDX_W-1:0] rs1, rs2, rd;
   logic [XLEN-1:0]      wb_wdata, rs1_val, rs2_val, imm, op_b_d;
   logic                 wb_we, stall, accept;

   logic                 out_valid_q, out_is_load_q, out_reg_write_q;
   logic [XLEN-1:0]      out_op_a_q, out_op_b_q, out_store_data_q;
   logic [4:0]           out_rd_q;

   assign rs1 = in_instr[RS1_LSB +: REG_IDX_W];
   assign rs2 = in_instr[RS2_LSB +: REG_IDX_W];
   assign rd  = in_instr[RD_LSB  +: REG_IDX_W];

   function automatic logic idx_ok(input logic [4:0] idx);
      return (NREGS == 32) || !idx[4];
   endfunction

   assign wb_wdata = wb_sel_pc4 ? wb_pc4 : wb_data;
   assign wb_we    = wb_en && (wb_rd != '0) && idx_ok(wb_rd);

   always_comb begin
      rs1_val = ((rs1 == '0) || !idx_ok(rs1)) ? '0 : rf_q[rs1];
      rs2_val = ((rs2 == '0) || !idx_ok(rs2)) ? '0 : rf_q[rs2];
`ifdef DECODE_STAGE_WB_BYPASS_EN
      // wb_we already excludes x0 and out-of-range indices.
      if (wb_we && (wb_rd == rs1)) rs1_val = wb_wdata;
      if (wb_we && (wb_rd == rs2)) rs2_val = wb_wdata;
`endif
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr_i (in_instr),
      .imm_o   (imm)
   );

   // Load-use hazard: rs2 compared even for formats without rs2 (conservative).
   assign stall = out_valid_q && out_is_load_q && (out_rd_q != '0) &&
                  ((out_rd_q == rs1) || (out_rd_q == rs2));

   assign in_ready = !reset && !flush && !stall && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      if (in_shift_imm)    op_b_d = XLEN'(in_instr[24:20]);
      else if (in_alu_src) op_b_d = imm;
      else                 op_b_d = rs2_val;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_we) begin
         rf_q[wb_rd] <= wb_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q      <= 1'b0;
         out_op_a_q       <= '0;
         out_op_b_q       <= '0;
         out_store_data_q <= '0;
         out_rd_q         <= '0;
         out_is_load_q    <= 1'b0;
         out_reg_write_q  <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q      <= 1'b1;
         out_op_a_q       <= rs1_val;
         out_op_b_q       <= op_b_d;
         out_store_data_q <= rs2_val;
         out_rd_q         <= rd;
         out_is_load_q    <= in_is_load;
         out_reg_write_q  <= writes_rd(in_instr[OPC_LSB +: OPC_W]);
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_op_a       = out_op_a_q;
   assign out_op_b       = out_op_b_q;
   assign out_store_data = out_store_data_q;
   assign out_rd         = out_rd_q;
   assign out_is_load    = out_is_load_q;
   assign out_reg_write  = out_reg_write_q;

endmodule
